// File: rtl/reg_write_buffer.sv
// rtl/reg_write_buffer.sv - in-order register write FIFO with forwarding lookup
// Lookup comparators are built only when REG_WRITE_BUFFER_FORWARD_EN is defined.
module reg_write_buffer #(
   parameter int WordLen   = 32,
   parameter int WordCount = 16,
   parameter int Depth     = 4,
   localparam int RW = $clog2(WordCount),
   localparam int CW = $clog2(Depth) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inValid,
   output logic               inReady,
   input  logic [RW-1:0]      inReg,
   input  logic [WordLen-1:0] inData,
   input  logic               drainEn,
   output logic               wbRegWrite,
   output logic [RW-1:0]      wbReg,
   output logic [WordLen-1:0] wbData,
   input  logic [RW-1:0]      lookupReg,
   output logic               lookupHit,
   output logic [WordLen-1:0] lookupData,
   output logic [CW-1:0]      count
);

   localparam int PW = CW - 1;

   logic [RW-1:0]      mem_reg_q  [Depth];
   logic [RW-1:0]      mem_reg_d  [Depth];
   logic [WordLen-1:0] mem_data_q [Depth];
   logic [WordLen-1:0] mem_data_d [Depth];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic               wb_write_q, wb_write_d;
   logic [RW-1:0]      wb_reg_q, wb_reg_d;
   logic [WordLen-1:0] wb_data_q, wb_data_d;
   logic               push;
   logic               pop;

   // Ready depends only on registered occupancy, so a full buffer refuses even during a pop.
   assign inReady = (count_q < CW'(Depth));

   always_comb begin
      push       = inValid && inReady;
      pop        = drainEn && (count_q != '0);
      mem_reg_d  = mem_reg_q;
      mem_data_d = mem_data_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      wb_write_d = 1'b0;
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;
      if (push) begin
         mem_reg_d[tail_q]  = inReg;
         mem_data_d[tail_q] = inData;
         tail_d             = tail_q + 1'b1;
      end
      if (pop) begin
         wb_write_d = 1'b1;
         wb_reg_d   = mem_reg_q[head_q];
         wb_data_d  = mem_data_q[head_q];
         head_d     = head_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         wb_write_q <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         wb_write_q <= wb_write_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_reg_q  <= mem_reg_d;
      mem_data_q <= mem_data_d;
   end

   assign wbRegWrite = wb_write_q;
   assign wbReg      = wb_reg_q;
   assign wbData     = wb_data_q;
   assign count      = count_q;

`ifdef REG_WRITE_BUFFER_FORWARD_EN
   logic [PW-1:0] lk_idx;

   // Scan wb stage first, then FIFO oldest to youngest; later matches override earlier ones.
   always_comb begin
      lookupHit  = 1'b0;
      lookupData = '0;
      lk_idx     = head_q;
      if (wb_write_q && (wb_reg_q == lookupReg)) begin
         lookupHit  = 1'b1;
         lookupData = wb_data_q;
      end
      for (int i = 0; i < Depth; i++) begin
         lk_idx = head_q + PW'(i);
         if ((i < int'(count_q)) && (mem_reg_q[lk_idx] == lookupReg)) begin
            lookupHit  = 1'b1;
            lookupData = mem_data_q[lk_idx];
         end
      end
   end
`else
   logic unused_lookup;

   assign unused_lookup = ^lookupReg;
   assign lookupHit     = 1'b0;
   assign lookupData    = '0;
`endif

endmodule

// File: tb/tb_reg_write_buffer.sv
// tb/tb_reg_write_buffer.sv - self-checking bench for reg_write_buffer
// Expected lookup results follow REG_WRITE_BUFFER_FORWARD_EN.
module tb_reg_write_buffer;

`ifdef REG_WRITE_BUFFER_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [3:0]  inReg;
   logic [31:0] inData;
   logic        drainEn;
   logic        wbRegWrite;
   logic [3:0]  wbReg;
   logic [31:0] wbData;
   logic [3:0]  lookupReg;
   logic        lookupHit;
   logic [31:0] lookupData;
   logic [2:0]  count;

   reg_write_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inValid    (inValid),
      .inReady    (inReady),
      .inReg      (inReg),
      .inData     (inData),
      .drainEn    (drainEn),
      .wbRegWrite (wbRegWrite),
      .wbReg      (wbReg),
      .wbData     (wbData),
      .lookupReg  (lookupReg),
      .lookupHit  (lookupHit),
      .lookupData (lookupData),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [3:0]  r;
      logic [31:0] d;
      logic        dr;
      logic [3:0]  lk;
      logic [2:0]  cnt;
      logic        rdy;
      logic        wbw;
      logic [3:0]  wbr;
      logic [31:0] wbd;
      logic        hit;
      logic [31:0] ld;
   } vec_t;

   typedef struct packed {
      logic [3:0]  r;
      logic [31:0] d;
   } wr_t;

   vec_t tbl [21];
   wr_t  exp_q [$];
   int   m_cnt;
   int   checks;
   int   failures;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] r, input logic [31:0] d,
                        input logic dr, input logic [3:0] lk);
      inValid   = v;
      inReg     = r;
      inData    = d;
      drainEn   = dr;
      lookupReg = lk;
   endtask

   task automatic chk_lookup(input string nm, input logic hit, input logic [31:0] ld);
      chk({nm, "_hit"}, 32'(lookupHit), 32'(hit & FWD));
      chk({nm, "_ldata"}, lookupData, FWD ? ld : 32'h0);
   endtask

   // One clock: model occupancy, queue accepted writes, compare drained writes.
   task automatic cycle();
      logic acc;
      logic pop;
      wr_t  w;
      acc = inValid && (m_cnt < 4);
      pop = drainEn && (m_cnt > 0);
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back({inReg, inData});
      if (acc && !pop) m_cnt++;
      else if (pop && !acc) m_cnt--;
      chk("sb_wbw", 32'(wbRegWrite), 32'(pop));
      if (wbRegWrite && exp_q.size() > 0) begin
         w = exp_q.pop_front();
         chk("sb_reg", 32'(wbReg), 32'(w.r));
         chk("sb_data", wbData, w.d);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_cnt    = 0;

      // fill/backpressure, full with simultaneous pop, then same-register and R0
      tbl[0]  = '{1'b1, 4'd1, 32'h11, 1'b0, 4'd1, 3'd1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 32'h11};
      tbl[1]  = '{1'b1, 4'd2, 32'h22, 1'b0, 4'd1, 3'd2, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 32'h11};
      tbl[2]  = '{1'b1, 4'd3, 32'h33, 1'b0, 4'd3, 3'd3, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 32'h33};
      tbl[3]  = '{1'b1, 4'd4, 32'h44, 1'b0, 4'd4, 3'd4, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 32'h44};
      tbl[4]  = '{1'b1, 4'd5, 32'h55, 1'b0, 4'd5, 3'd4, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 4'd5, 32'h55, 1'b1, 4'd1, 3'd3, 1'b1, 1'b1, 4'd1, 32'h11, 1'b1, 32'h11};
      tbl[6]  = '{1'b1, 4'd5, 32'h55, 1'b1, 4'd5, 3'd3, 1'b1, 1'b1, 4'd2, 32'h22, 1'b1, 32'h55};
      tbl[7]  = '{1'b1, 4'd6, 32'h66, 1'b1, 4'd2, 3'd3, 1'b1, 1'b1, 4'd3, 32'h33, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 3'd2, 1'b1, 1'b1, 4'd4, 32'h44, 1'b1, 32'h66};
      tbl[9]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 3'd1, 1'b1, 1'b1, 4'd5, 32'h55, 1'b1, 32'h66};
      tbl[10] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 3'd0, 1'b1, 1'b1, 4'd6, 32'h66, 1'b1, 32'h66};
      tbl[11] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 3'd0, 1'b1, 1'b0, 4'd6, 32'h66, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd6, 32'h66, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 4'd5, 32'h1, 1'b0, 4'd5, 3'd1, 1'b1, 1'b0, 4'd6, 32'h66, 1'b1, 32'h1};
      tbl[14] = '{1'b1, 4'd5, 32'h2, 1'b0, 4'd5, 3'd2, 1'b1, 1'b0, 4'd6, 32'h66, 1'b1, 32'h2};
      tbl[15] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 3'd1, 1'b1, 1'b1, 4'd5, 32'h1, 1'b1, 32'h2};
      tbl[16] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 3'd0, 1'b1, 1'b1, 4'd5, 32'h2, 1'b1, 32'h2};
      tbl[17] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 3'd0, 1'b1, 1'b0, 4'd5, 32'h2, 1'b0, 32'h0};
      tbl[18] = '{1'b1, 4'd0, 32'hA5, 1'b1, 4'd0, 3'd1, 1'b1, 1'b0, 4'd5, 32'h2, 1'b1, 32'hA5};
      tbl[19] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 32'hA5, 1'b1, 32'hA5};
      tbl[20] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 32'hA5, 1'b0, 32'h0};

      rst_n = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(inReady), 32'd1);
      chk("rst_wbw", 32'(wbRegWrite), 32'd0);
      chk("rst_wbreg", 32'(wbReg), 32'd0);
      chk("rst_wbdata", wbData, 32'd0);
      chk("rst_hit", 32'(lookupHit), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single write with drain enabled
      drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd3);
      cycle();
      chk("sw_e1_count", 32'(count), 32'd1);
      chk_lookup("sw_e1", 1'b1, 32'hDEADBEEF);
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3);
      cycle();
      chk("sw_e2_wbw", 32'(wbRegWrite), 32'd1);
      chk("sw_e2_wbreg", 32'(wbReg), 32'd3);
      chk("sw_e2_wbdata", wbData, 32'hDEADBEEF);
      chk_lookup("sw_e2", 1'b1, 32'hDEADBEEF);
      cycle();
      chk("sw_e3_wbw", 32'(wbRegWrite), 32'd0);
      chk_lookup("sw_e3", 1'b0, 32'h0);

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].dr, tbl[i].lk);
         cycle();
         chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("t%0d_ready", i), 32'(inReady), 32'(tbl[i].rdy));
         chk($sformatf("t%0d_wbw", i), 32'(wbRegWrite), 32'(tbl[i].wbw));
         chk($sformatf("t%0d_wbreg", i), 32'(wbReg), 32'(tbl[i].wbr));
         chk($sformatf("t%0d_wbdata", i), wbData, tbl[i].wbd);
         chk_lookup($sformatf("t%0d", i), tbl[i].hit, tbl[i].ld);
      end

      // reset mid-operation with three entries pending
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(7 + i), 32'h70 + 32'(i), 1'b0, 4'd7);
         cycle();
      end
      chk("pre_rst_count", 32'(count), 32'd3);
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_wbw", 32'(wbRegWrite), 32'd0);
      chk("mid_rst_hit", 32'(lookupHit), 32'd0);
      #4;
      rst_n = 1'b1;
      exp_q.delete();
      m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk($sformatf("post_rst%0d_count", i), 32'(count), 32'd0);
         chk($sformatf("post_rst%0d_wbw", i), 32'(wbRegWrite), 32'd0);
      end

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_write_buffer.md
# reg_write_buffer

Write-side companion to the 16-entry register file: an in-order FIFO that queues register write requests (destination index, data) from the execute/memory stages and drains them one per cycle into the register file's single write port. Producers use a valid/ready handshake, and the write port is released by a `drainEn` grant. Because queued writes have not yet reached the register file, the block also provides a forwarding lookup so that readers see the newest pending value of a register.

## Interface
- `WordLen`, 32, data width in bits
- `WordCount`, 16, number of architectural registers; index width `RW = ceil(log2(WordCount))`
- `Depth`, 4, FIFO entries; must be a power of two and at least 2
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `inValid`  in  1  producer presents a write request
- `inReady`  out  1  buffer can accept a request this cycle
- `inReg`  in  RW  destination register index
- `inData`  in  WordLen  write data
- `drainEn`  in  1  register file write port is available to this block this cycle
- `wbRegWrite`  out  1  registered; drives the register file `regWrite`
- `wbReg`  out  RW  registered; drives the register file write index
- `wbData`  out  WordLen  registered; drives the register file write data
- `lookupReg`  in  RW  register index being read by a consumer
- `lookupHit`  out  1  a pending write to `lookupReg` exists
- `lookupData`  out  WordLen  value of the newest pending write to `lookupReg`
- `count`  out  `ceil(log2(Depth))+1`  number of occupied FIFO entries

## Operation
- FIFO storage, head/tail pointers, and `count`. Pointers wrap modulo `Depth`.
- `inReady = (count < Depth)`, a pure function of registered state. There is no combinational path from `drainEn`, so a full buffer refuses a push even when a pop happens in the same cycle.
- Push occurs when `inValid && inReady`: the entry is written at `tail`, and `tail` increments.
- Pop occurs when `drainEn && count > 0`: the head entry is loaded into `wbReg`/`wbData`, `wbRegWrite` is set to 1, and `head` increments. Otherwise `wbRegWrite` is set to 0, and `wbReg`/`wbData` hold their values.
- Push and pop in the same cycle leave `count` unchanged. Push alone increments `count`; pop alone decrements it.
- All register indices, including 0, are treated identically. There is no special-casing.
- Write order into the register file is exactly the acceptance order.
- Lookup (combinational) searches the valid FIFO entries from youngest to oldest, then the wb stage (`wbRegWrite` set). The first match gives `lookupHit = 1` and its data; if nothing matches, `lookupHit = 0` and `lookupData = 0`.
- The wb stage is included in the lookup because the register file commits on the negedge, mid-cycle. A reader earlier in that cycle would otherwise see stale data.

## Timing
- Reset state (asynchronous, immediate): `count = 0`, `head = tail = 0`, `wbRegWrite = 0`, `wbReg = 0`, `wbData = 0`. As a result `inReady = 1` and `lookupHit = 0`.
- Reset mid-operation discards every pending entry and produces no partial write.
- Latency, empty buffer with `drainEn = 1`: a push at edge N gives `wbRegWrite = 1` with that entry after edge N+1.
- The entry is visible to lookup from edge N onward, continuously, until `wbRegWrite` falls for it.
- Throughput is one push and one pop per cycle. A sustained push stream with `drainEn = 1` holds `count` at 1.
- Full buffer (`count = Depth`): `inReady = 0` for that cycle. It becomes 1 the cycle after a pop.
- `drainEn` low with the buffer empty keeps `wbRegWrite = 0`.

## Configuration
- Macro: `REG_WRITE_BUFFER_FORWARD_EN`.
- Defined: the lookup logic is built as specified.
- Undefined: no lookup comparators are built, `lookupHit` is tied to 0, and `lookupData` is tied to 0. The `lookupReg` input is ignored. FIFO and write-port behaviour are identical in both builds.

## Test plan
- Single write: after reset, push R3 = 0xDEADBEEF at edge 1 with `drainEn = 1`. Required response:
  - after edge 2: `wbRegWrite = 1`, `wbReg = 3`, `wbData = 0xDEADBEEF`
  - after edge 3: `wbRegWrite = 0`
  - `lookupReg = 3` hits with 0xDEADBEEF between edge 1 and edge 3.
- Fill and backpressure: with `drainEn = 0`, hold `inValid` high while pushing R1..R6 = 0x11..0x66. Required response:
  - four pushes are accepted, `count = 4`, `inReady = 0`
  - raising `drainEn` produces writes R1..R4 in order, then R5 and R6 are accepted and written in order.
- Full plus simultaneous pop: with `count = 4`, `drainEn = 1` and `inValid = 1`. Required response: the push is refused that cycle and `count = 3`; the push is accepted the next cycle and `count` stays 3.
- Same-register priority: with `drainEn = 0`, push R5 = 1, then R5 = 2. Required response:
  - `lookup(5)` returns 2
  - on drain, the write sequence is 1 then 2
  - while the wb stage holds 2 and the FIFO is empty, `lookup(5)` still returns 2.
- Reset mid-operation: with 3 entries pending, pulse `rst_n` low for half a cycle. Required response: `count = 0` and `wbRegWrite = 0` immediately, and no write follows.
- Macro undefined: repeat the single-write test. Required response: identical wb outputs, and `lookupHit` stays 0 throughout.
